// File: rtl/pipemem_dcache.sv
// pipemem_dcache: direct-mapped, write-through, no-write-allocate data cache
// for the MEM stage of the 5-stage MIPS32 pipeline.
//
// Ports
//   clock, resetn          clock; synchronous active-low reset
//   mm2reg, mwmem          MEM-stage load / store request (store wins)
//   malu, mb               byte address (word access), store data
//   imem_ready             I-cache ready; pipeline advances on mem_ready & imem_ready
//   mem_ready              MEM stage complete this cycle (combinational)
//   mmo                    load data (hit word on a load hit, else 0)
//   mem_req/we/addr/wdata  single-word request to main memory
//   mem_rdata, mem_ack     main memory response; a word completes on req & ack
module pipemem_dcache #(
  parameter int LINES = 64,
  parameter int WORDS = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic        imem_ready,
  output logic        mem_ready,
  output logic [31:0] mmo,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [OFF_W-1:0]   cnt_q, cnt_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES][WORDS];

  logic [OFF_W-1:0]   off;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               hit, is_load, is_store;
  logic               unused_byte_bits;

  // Write port into the line storage, selected by the FSM.
  logic               data_we, tag_we;
  logic [OFF_W-1:0]   data_off;
  logic [31:0]        data_wdata;

  assign off      = malu[2 +: OFF_W];
  assign idx      = malu[2 + OFF_W +: IDX_W];
  assign tag      = malu[31 -: TAG_W];
  assign is_store = mwmem;
  assign is_load  = mm2reg & ~mwmem;
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign mmo      = (is_load && hit) ? data_q[idx][off] : 32'd0;
  assign unused_byte_bits = ^malu[1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    mem_ready  = 1'b1;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    data_we    = 1'b0;
    tag_we     = 1'b0;
    data_off   = cnt_q;
    data_wdata = mem_rdata;
    case (state_q)
      S_IDLE: begin
        if (is_store) begin
          mem_ready = 1'b0;
          state_d   = S_WRITE;
        end else if (is_load && !hit) begin
          mem_ready    = 1'b0;
          state_d      = S_REFILL;
          cnt_d        = '0;
          // Old contents die now so a half-filled line never hits.
          valid_d[idx] = 1'b0;
        end
      end
      S_REFILL: begin
        mem_ready = 1'b0;
        mem_req   = 1'b1;
        mem_addr  = {tag, idx, cnt_q, 2'b00};
        if (mem_ack) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == OFF_W'(WORDS - 1)) begin
            valid_d[idx] = 1'b1;
            tag_we       = 1'b1;
            state_d      = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        mem_ready = 1'b0;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {malu[31:2], 2'b00};
        mem_wdata = mb;
        if (mem_ack) begin
          // Write-through: only refresh the cached copy if present.
          data_we    = hit;
          data_off   = off;
          data_wdata = mb;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        // Hold here until the pipeline actually advances so the same
        // store is not issued to memory a second time.
        if (imem_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // Line storage carries no reset; valid_q alone decides visibility.
  always_ff @(posedge clock) begin
    if (resetn && data_we) data_q[idx][data_off] <= data_wdata;
    if (resetn && tag_we)  tag_q[idx]            <= tag;
  end

endmodule
